// File: rtl/cce_deadlock_report_tx.sv
// Deadlock report transmitter: qualifies the monitor block level over THRESHOLD cycles,
// timestamps the detection, sends a 2-word AXI-Stream report and holds a sticky flag.
module cce_deadlock_report_tx #(
  parameter int unsigned THRESHOLD = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        block_in,
  input  logic        clear,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        deadlock,
  output logic [15:0] event_count
);

  typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_TS, LATCHED} state_t;

  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(THRESHOLD - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] run_cnt, run_next;
  logic [31:0]      ts_cnt, ts_cap;
  logic             detect;

  // clear takes priority over a coincident detection
  assign detect = (state == IDLE) && block_in && !clear && (run_cnt == RUN_LAST);

  always_comb begin
    state_next = state;
    run_next   = '0;
    case (state)
      IDLE: begin
        if (detect) begin
          state_next = SEND_HDR;
        end else if (block_in && !clear) begin
          run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        end
      end
      SEND_HDR: if (m_tready) state_next = SEND_TS;
      SEND_TS:  if (m_tready) state_next = LATCHED;
      LATCHED:  if (clear)    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = '0;
    case (state)
      SEND_HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {16'hDEAD, event_count};
      end
      SEND_TS: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tdata  = ts_cap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      run_cnt     <= '0;
      ts_cnt      <= '0;
      ts_cap      <= '0;
      deadlock    <= 1'b0;
      event_count <= '0;
    end else begin
      state   <= state_next;
      run_cnt <= run_next;
      ts_cnt  <= ts_cnt + 32'd1;
      if (detect) begin
        ts_cap   <= ts_cnt;
        deadlock <= 1'b1;
        if (event_count != 16'hFFFF) event_count <= event_count + 16'd1;
      end else if (state == LATCHED && clear) begin
        deadlock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cce_deadlock_report_tx.sv
// Self-checking bench for cce_deadlock_report_tx using a queue-based packet reference model.
module tb_cce_deadlock_report_tx;

  localparam int TH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        block_in, clear, m_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, deadlock;
  logic [15:0] event_count;

  logic        blk1, clr1;
  logic [31:0] m1_tdata;
  logic        m1_tvalid, m1_tlast, dl1;
  logic [15:0] evt1;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] ts_m, ts_cap_m;
  logic [32:0] q[$];
  bit          latched_m, dl_m;
  int          run_m, evt_m;

  cce_deadlock_report_tx #(.THRESHOLD(TH), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .block_in(block_in), .clear(clear),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .deadlock(deadlock), .event_count(event_count)
  );

  cce_deadlock_report_tx #(.THRESHOLD(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .block_in(blk1), .clear(clr1),
    .m_tdata(m1_tdata), .m_tvalid(m1_tvalid), .m_tready(m_tready), .m_tlast(m1_tlast),
    .deadlock(dl1), .event_count(evt1)
  );

  always #5 clock = ~clock;

  function automatic logic [50:0] obs();
    return {m_tvalid, m_tlast, m_tdata, deadlock, event_count};
  endfunction

  function automatic logic [50:0] exp_out();
    logic [32:0] w;
    logic        v;
    v = (q.size() != 0);
    w = v ? q[0] : 33'd0;
    return {v, w[32], w[31:0], dl_m, evt_m[15:0]};
  endfunction

  task automatic model_reset();
    ts_m = '0; ts_cap_m = '0; q.delete();
    latched_m = 0; dl_m = 0; run_m = 0; evt_m = 0;
  endtask

  // A report is in flight while words are queued; once the last word goes the flag is latched.
  task automatic model_update();
    if (q.size() != 0) begin
      if (m_tready) begin
        void'(q.pop_front());
        if (q.size() == 0) latched_m = 1;
      end
    end else if (latched_m) begin
      if (clear) begin latched_m = 0; dl_m = 0; run_m = 0; end
    end else if (clear || !block_in) begin
      run_m = 0;
    end else if (run_m == TH - 1) begin
      if (evt_m < 65535) evt_m++;
      dl_m = 1;
      ts_cap_m = ts_m;
      q.push_back({1'b0, 16'hDEAD, evt_m[15:0]});
      q.push_back({1'b1, ts_m});
      run_m = 0;
    end else begin
      run_m++;
    end
    ts_m = ts_m + 32'd1;
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; block_in = 1'b0; clear = 1'b0; m_tready = 1'b1; blk1 = 1'b0; clr1 = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 51'd0) begin errors++; $display("FAIL reset_initial: got %h expected 0", obs()); end
    for (int i = 0; i < 3; i++) begin
      block_in = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      checks++;
      if (obs() !== 51'd0 || m1_tvalid !== 1'b0) begin
        errors++; $display("FAIL reset_hold: got %h tvalid1=%b expected 0", obs(), m1_tvalid);
      end
    end
    reset = 1'b0; block_in = 1'b0;
  endtask

  task automatic test_short_bursts();
    m_tready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        block_in = (c < 3);
        step();
        checks++;
        if (obs() !== exp_out()) begin errors++; $display("FAIL short_bursts: got %h expected %h", obs(), exp_out()); end
      end
    end
    block_in = 1'b0;
    checks++;
    if (deadlock !== 1'b0 || event_count !== 16'd0) begin
      errors++; $display("FAIL short_bursts_flags: deadlock=%b count=%h expected 0/0", deadlock, event_count);
    end
  endtask

  task automatic test_detect();
    m_tready = 1'b1; block_in = 1'b0;
    for (int i = 0; i < 200 && ts_m != 32'd100; i++) begin
      step();
      checks++;
      if (obs() !== exp_out()) begin errors++; $display("FAIL detect_wait: got %h expected %h", obs(), exp_out()); end
    end
    checks++;
    if (ts_m != 32'd100) begin errors++; $display("FAIL detect_ts_align: got %0d expected 100", ts_m); end
    block_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs() !== exp_out()) begin errors++; $display("FAIL detect_run: got %h expected %h", obs(), exp_out()); end
    end
    block_in = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hDEAD0001 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL detect_hdr: got v=%b d=%h l=%b expected 1/DEAD0001/0", m_tvalid, m_tdata, m_tlast);
    end
    step();
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h00000067 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL detect_ts: got v=%b d=%h l=%b expected 1/00000067/1", m_tvalid, m_tdata, m_tlast);
    end
    step();
    checks++;
    if (m_tvalid !== 1'b0 || deadlock !== 1'b1 || obs() !== exp_out()) begin
      errors++; $display("FAIL detect_latched: got %h expected %h", obs(), exp_out());
    end
  endtask

  task automatic test_backpressure();
    clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if (deadlock !== 1'b0) begin errors++; $display("FAIL bp_clear: got deadlock=%b expected 0", deadlock); end
    block_in = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    block_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'hDEAD0002 || m_tlast !== 1'b0) begin
        errors++; $display("FAIL bp_hdr_hold: got v=%b d=%h l=%b expected 1/DEAD0002/0", m_tvalid, m_tdata, m_tlast);
      end
      step();
    end
    m_tready = 1'b1; step(); m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== ts_cap_m || m_tlast !== 1'b1) begin
        errors++; $display("FAIL bp_ts_hold: got v=%b d=%h l=%b expected 1/%h/1", m_tvalid, m_tdata, m_tlast, ts_cap_m);
      end
      step();
    end
    m_tready = 1'b1; step();
    checks++;
    if (obs() !== exp_out() || m_tvalid !== 1'b0 || deadlock !== 1'b1) begin
      errors++; $display("FAIL bp_done: got %h expected %h", obs(), exp_out());
    end
  endtask

  task automatic test_latched_clear();
    block_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (m_tvalid !== 1'b0 || obs() !== exp_out()) begin errors++; $display("FAIL latched_block: got %h expected %h", obs(), exp_out()); end
    end
    block_in = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if (deadlock !== 1'b0) begin errors++; $display("FAIL latched_clear: got deadlock=%b expected 0", deadlock); end
    block_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    block_in = 1'b0;
    checks++;
    if (m_tdata !== 32'hDEAD0003 || obs() !== exp_out()) begin
      errors++; $display("FAIL latched_hdr3: got %h expected %h", obs(), exp_out());
    end
    clear = 1'b1; step(); clear = 1'b0;
    step();
    checks++;
    if (deadlock !== 1'b1 || m_tvalid !== 1'b0 || obs() !== exp_out()) begin
      errors++; $display("FAIL clear_in_send: got %h expected %h", obs(), exp_out());
    end
    clear = 1'b1; step(); clear = 1'b0;
    block_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    clear = 1'b1; step(); clear = 1'b0; block_in = 1'b0;
    step();
    checks++;
    if (m_tvalid !== 1'b0 || event_count !== 16'd3 || obs() !== exp_out()) begin
      errors++; $display("FAIL clear_vs_detect: got %h expected %h", obs(), exp_out());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      block_in = ($urandom_range(0, 9) < 8);
      clear    = ($urandom_range(0, 19) == 0);
      m_tready = ($urandom_range(0, 2) != 0);
      step();
      checks++;
      if (obs() !== exp_out()) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs(), exp_out()); end
    end
    block_in = 1'b0; clear = 1'b0;
  endtask

  task automatic test_async_reset();
    m_tready = 1'b1; clear = 1'b1; block_in = 1'b0;
    for (int i = 0; i < 50 && (q.size() != 0 || latched_m); i++) step();
    clear = 1'b0;
    block_in = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    block_in = 1'b0; m_tready = 1'b1; step(); m_tready = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || obs() !== exp_out()) begin
      errors++; $display("FAIL arst_setup: got %h expected %h", obs(), exp_out());
    end
    #2; reset = 1'b1; #1;
    model_reset();
    checks++;
    if (m_tvalid !== 1'b0 || deadlock !== 1'b0 || event_count !== 16'd0 || m_tdata !== 32'd0) begin
      errors++; $display("FAIL arst_async: got %h expected 0", obs());
    end
    @(posedge clock); #1;
    reset = 1'b0; block_in = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    block_in = 1'b0;
    checks++;
    if (m_tdata !== 32'hDEAD0001 || obs() !== exp_out()) begin
      errors++; $display("FAIL arst_hdr: got %h expected %h", obs(), exp_out());
    end
    step();
    checks++;
    if (m_tdata !== 32'd3 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL arst_ts_restart: got d=%h l=%b expected 00000003/1", m_tdata, m_tlast);
    end
    step();
  endtask

  task automatic test_threshold_one();
    logic [31:0] ts1;
    m_tready = 1'b1;
    ts1 = ts_m;
    blk1 = 1'b1; step(); blk1 = 1'b0;
    checks++;
    if (m1_tvalid !== 1'b1 || m1_tdata !== 32'hDEAD0001 || m1_tlast !== 1'b0) begin
      errors++; $display("FAIL th1_hdr: got v=%b d=%h l=%b expected 1/DEAD0001/0", m1_tvalid, m1_tdata, m1_tlast);
    end
    step();
    checks++;
    if (m1_tdata !== ts1 || m1_tlast !== 1'b1) begin
      errors++; $display("FAIL th1_ts: got d=%h l=%b expected %h/1", m1_tdata, m1_tlast, ts1);
    end
    step();
    checks++;
    if (m1_tvalid !== 1'b0 || dl1 !== 1'b1 || evt1 !== 16'd1) begin
      errors++; $display("FAIL th1_latched: got v=%b dl=%b cnt=%h expected 0/1/0001", m1_tvalid, dl1, evt1);
    end
  endtask

  initial begin
    test_reset();
    test_short_bursts();
    test_detect();
    test_backpressure();
    test_latched_clear();
    test_random();
    test_async_reset();
    test_threshold_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
